// File: rtl/comma_align.sv
// comma_align: 10b word aligner for the serdes rx path.
// Finds the bit offset of the comma within a two-word window of the raw
// stream, qualifies it over several consecutive commas before declaring lock,
// then holds that offset until commas keep arriving elsewhere, stop arriving,
// or the line reports loss of signal.
module comma_align #(
    parameter logic [6:0] COMMA      = 7'b0011111,
    parameter int         LOCK_COUNT = 3,
    parameter int         LOSS_COUNT = 4,
    parameter int         GAP_AW     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_raw,
    input  logic       rx_los,
    output logic [9:0] rxd,
    output logic       comma,
    output logic       locked,
    output logic [3:0] offset,
    output logic [7:0] realign_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(LOSS_COUNT);
    localparam logic [GAP_AW-1:0] GAP_MAX   = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          p_q, p_d;
    logic [9:0]          rxd_q, rxd_d;
    logic                comma_q, comma_d;
    logic                locked_q, locked_d;
    logic [3:0]          offset_q, offset_d;
    logic [7:0]          realign_q, realign_d;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
    logic [GAP_AW-1:0]   gap_q, gap_d, gap_inc;

    // The top bit of the current raw word never falls inside any of the ten
    // candidates this cycle; it is only consumed next cycle through p_q.
    logic [18:0]         window;
    logic [9:0]          match;
    logic                any_match;
    logic [3:0]          first_k;
    logic                cur_match;

    // Flag every candidate offset whose low seven bits hold a comma of either polarity.
    always_comb begin
        window = {rx_raw[8:0], p_q};
        match  = '0;
        for (int k = 0; k < 10; k++) begin
            match[k] = (window[k +: 7] == COMMA) || (window[k +: 7] == ~COMMA);
        end
    end

    // Reduce the match vector: lowest matching offset, and whether the held offset matched.
    always_comb begin
        any_match = |match;
        first_k   = 4'd0;
        cur_match = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            if (match[k]) begin
                first_k = 4'(k);
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (offset_q == 4'(k)) begin
                cur_match = match[k];
            end
        end
    end

    // Alignment FSM: hunt for a comma, confirm it, then hold lock until it is lost.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        good_d    = good_q;
        miss_d    = miss_q;
        gap_d     = gap_q;
        realign_d = realign_q;
        p_d       = rx_raw;

        good_inc  = good_q + 1'b1;
        miss_inc  = miss_q + 1'b1;
        gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

        if (rx_los) begin
            state_d = HUNT;
            good_d  = '0;
            miss_d  = '0;
            gap_d   = '0;
            if (state_q == LOCKED) begin
                realign_d = realign_q + 8'd1;
            end
        end else begin
            case (state_q)
                HUNT: begin
                    if (any_match) begin
                        offset_d = first_k;
                        good_d   = GOOD_ONE;
                        miss_d   = '0;
                        gap_d    = '0;
                        state_d  = (GOOD_ONE >= GOOD_MAX) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (cur_match) begin
                        gap_d  = '0;
                        good_d = good_inc;
                        if (good_inc >= GOOD_MAX) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            miss_d  = '0;
                        end
                    end else if (any_match) begin
                        // A comma somewhere else restarts qualification at that offset.
                        offset_d = first_k;
                        good_d   = GOOD_ONE;
                        gap_d    = '0;
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc == GAP_MAX) begin
                            state_d = HUNT;
                            good_d  = '0;
                            gap_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (cur_match) begin
                        miss_d = '0;
                        gap_d  = '0;
                    end else begin
                        gap_d = gap_inc;
                        if (any_match) begin
                            miss_d = miss_inc;
                        end
                        if ((any_match && (miss_inc >= MISS_MAX)) || (gap_inc == GAP_MAX)) begin
                            state_d   = HUNT;
                            realign_d = realign_q + 8'd1;
                            good_d    = '0;
                            miss_d    = '0;
                            gap_d     = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // Output word is taken at the offset in force after this edge so a newly found comma is emitted aligned.
    always_comb begin
        rxd_d   = window[9:0];
        comma_d = match[0];
        for (int k = 0; k < 10; k++) begin
            if (offset_d == 4'(k)) begin
                rxd_d   = window[k +: 10];
                comma_d = match[k];
            end
        end
    end

    // State and output registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            p_q       <= '0;
            rxd_q     <= '0;
            comma_q   <= 1'b0;
            locked_q  <= 1'b0;
            offset_q  <= '0;
            realign_q <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            rxd_q     <= rxd_d;
            comma_q   <= comma_d;
            locked_q  <= locked_d;
            offset_q  <= offset_d;
            realign_q <= realign_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            gap_q     <= gap_d;
        end
    end

    assign rxd         = rxd_q;
    assign comma       = comma_q;
    assign locked      = locked_q;
    assign offset      = offset_q;
    assign realign_cnt = realign_q;

endmodule

// File: tb/tb_comma_align.sv
// tb_comma_align: directed bench for comma_align.
// Symbols are serialised low bit first and re-cut into raw words at a chosen
// bit shift, so a comma symbol sent at shift s is found at offset s on the
// edge after the following symbol is presented.
module tb_comma_align;

    localparam logic [9:0] K28_5 = 10'h11F;
    localparam logic [9:0] FILL  = 10'h2AA;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_raw;
    logic       rx_los;
    logic [9:0] rxd;
    logic       comma;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] realign_cnt;

    int         vecCount  = 0;
    int         missCount = 0;
    logic [9:0] prevSym   = '0;

    comma_align dut (
        .clk         (clk),
        .rst         (rst),
        .rx_raw      (rx_raw),
        .rx_los      (rx_los),
        .rxd         (rxd),
        .comma       (comma),
        .locked      (locked),
        .offset      (offset),
        .realign_cnt (realign_cnt)
    );

    // Free-running word clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one symbol, cut at the given bit shift, and step past the next edge.
    task automatic applyStimulus(input logic [9:0] sym, input int shift);
        logic [19:0] pair;
        pair    = {sym, prevSym};
        rx_raw  = pair[(10 - shift) +: 10];
        prevSym = sym;
        @(posedge clk);
        #1;
    endtask

    // Comma followed by one filler; returns just after the edge that detects the comma.
    task automatic sendComma(input int shift);
        applyStimulus(K28_5, shift);
        applyStimulus(FILL, shift);
    endtask

    // A run of filler symbols that contain no comma at any offset.
    task automatic sendFill(input int shift, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(FILL, shift);
        end
    endtask

    // Watchdog so the run always ends even if stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        rx_raw = '0;
        rx_los = 1'b0;
        #12;
        checkOutput("reset_locked",  32'(locked),      32'd0);
        checkOutput("reset_offset",  32'(offset),      32'd0);
        checkOutput("reset_rxd",     32'(rxd),         32'd0);
        checkOutput("reset_comma",   32'(comma),       32'd0);
        checkOutput("reset_realign", 32'(realign_cnt), 32'd0);
        rst = 1'b0;

        // Stream shifted by 3 bits: align on first comma, lock on the third.
        sendFill(3, 2);
        sendComma(3);
        checkOutput("shift3_c1_offset", 32'(offset), 32'd3);
        checkOutput("shift3_c1_rxd",    32'(rxd),    32'(K28_5));
        checkOutput("shift3_c1_comma",  32'(comma),  32'd1);
        checkOutput("shift3_c1_locked", 32'(locked), 32'd0);
        sendFill(3, 2);
        checkOutput("shift3_fill_rxd",   32'(rxd),   32'(FILL));
        checkOutput("shift3_fill_comma", 32'(comma), 32'd0);
        sendComma(3);
        checkOutput("shift3_c2_locked", 32'(locked), 32'd0);
        sendFill(3, 2);
        sendComma(3);
        checkOutput("shift3_c3_locked", 32'(locked), 32'd1);
        checkOutput("shift3_c3_rxd",    32'(rxd),    32'(K28_5));
        checkOutput("shift3_c3_comma",  32'(comma),  32'd1);
        sendFill(3, 2);

        // Three misplaced commas then one correct comma keep lock.
        for (int i = 0; i < 3; i++) begin
            sendComma(7);
            checkOutput("miss3_locked", 32'(locked), 32'd1);
            checkOutput("miss3_offset", 32'(offset), 32'd3);
            sendFill(7, 2);
        end
        sendComma(3);
        checkOutput("miss_reset_locked", 32'(locked), 32'd1);
        sendFill(3, 2);

        // Four further misplaced commas are needed to drop lock.
        for (int i = 0; i < 4; i++) begin
            sendComma(7);
            checkOutput("miss4_locked",  32'(locked),      (i < 3) ? 32'd1 : 32'd0);
            checkOutput("miss4_realign", 32'(realign_cnt), (i < 3) ? 32'd0 : 32'd1);
            sendFill(7, 2);
        end
        checkOutput("hunt_offset_held", 32'(offset), 32'd3);

        // Relock at offset 7 after three commas.
        for (int i = 0; i < 3; i++) begin
            sendComma(7);
            checkOutput("relock7_offset", 32'(offset), 32'd7);
            checkOutput("relock7_locked", 32'(locked), (i == 2) ? 32'd1 : 32'd0);
            sendFill(7, 2);
        end
        checkOutput("relock7_rxd_fill", 32'(rxd), 32'(FILL));

        // Comma gap: 254 words without comma keep lock, 255 drop it.
        sendComma(7);
        sendFill(7, 253);
        sendComma(7);
        checkOutput("gap254_locked", 32'(locked), 32'd1);
        checkOutput("gap254_comma",  32'(comma),  32'd1);
        sendFill(7, 254);
        checkOutput("gap254b_locked", 32'(locked), 32'd1);
        sendFill(7, 1);
        checkOutput("gap255_locked",  32'(locked),      32'd0);
        checkOutput("gap255_realign", 32'(realign_cnt), 32'd2);
        checkOutput("gap255_offset",  32'(offset),      32'd7);

        for (int i = 0; i < 3; i++) begin
            sendComma(7);
            sendFill(7, 2);
        end
        checkOutput("relock_gap_locked", 32'(locked), 32'd1);

        // One-cycle loss of signal drops lock on the next edge.
        rx_los = 1'b1;
        applyStimulus(FILL, 7);
        rx_los = 1'b0;
        checkOutput("los_locked",  32'(locked),      32'd0);
        checkOutput("los_realign", 32'(realign_cnt), 32'd3);
        checkOutput("los_offset",  32'(offset),      32'd7);

        for (int i = 0; i < 3; i++) begin
            sendComma(7);
            sendFill(7, 2);
        end
        checkOutput("relock_los_locked", 32'(locked), 32'd1);

        // Reset mid-lock clears everything without waiting for a clock edge.
        #3;
        rst    = 1'b1;
        rx_raw = '0;
        #1;
        checkOutput("midrst_locked",  32'(locked),      32'd0);
        checkOutput("midrst_rxd",     32'(rxd),         32'd0);
        checkOutput("midrst_comma",   32'(comma),       32'd0);
        checkOutput("midrst_offset",  32'(offset),      32'd0);
        checkOutput("midrst_realign", 32'(realign_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        prevSym = '0;

        // Window holding commas at offsets 2 and 8 together picks offset 2.
        rx_raw = 10'h07D;
        @(posedge clk);
        #1;
        checkOutput("dual_pre_comma",  32'(comma),  32'd0);
        checkOutput("dual_pre_offset", 32'(offset), 32'd0);
        rx_raw = 10'h158;
        @(posedge clk);
        #1;
        checkOutput("dual_offset", 32'(offset), 32'd2);
        checkOutput("dual_rxd",    32'(rxd),    32'h01F);
        checkOutput("dual_comma",  32'(comma),  32'd1);
        checkOutput("dual_locked", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/comma_align.md
COMMA_ALIGN -- requirements
Module: comma_align

Interface
REQ-001 SHALL have parameter COMMA, default 7'b0011111, the comma pattern matched on candidate bits [6:0]; its complement also matches.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, the number of consecutive same-offset commas, including the first, required to lock.
REQ-003 SHALL have parameter LOSS_COUNT, default 4, the number of consecutive wrong-offset commas that drop lock.
REQ-004 SHALL have parameter GAP_AW, default 8, the gap counter width; the maximum comma gap is 2^GAP_AW-1 words.
REQ-005 SHALL have port clk  input  1  the only clock, in the serdes rx word domain.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port rx_raw  input  10  unaligned serdes word, one per clk.
REQ-008 SHALL have port rx_los  input  1  loss-of-signal, synchronous to clk.
REQ-009 SHALL have port rxd  output  10  aligned 10b symbol, feeding the gmii_link rxdata path.
REQ-010 SHALL have port comma  output  1  rxd holds a comma in either polarity.
REQ-011 SHALL have port locked  output  1  alignment locked.
REQ-012 SHALL have port offset  output  4  current bit offset, 0..9.
REQ-013 SHALL have port realign_cnt  output  8  count of lock losses, wraps modulo 256.

Function
REQ-014 SHALL register the previous raw word P; window W = {rx_raw, P} (20b); candidate k = W[k+9:k] for k = 0..9.
REQ-015 SHALL flag candidate k as a comma when its bits [6:0] equal COMMA or ~COMMA.
REQ-016 SHALL select the lowest k when several candidates are commas in the same cycle.
REQ-017 SHALL on each clk edge load rxd with W[o+9:o] and comma with that word's match flag, where o is the offset value after that edge; latency is 1 clk from rx_raw, 2 from the earlier half of W.
REQ-018 SHALL implement FSM states HUNT, CHECK and LOCKED; locked = 1 only in LOCKED.
REQ-019 SHALL in HUNT, on any comma at offset k, set offset to k, set good count to 1, clear the gap counter and go to CHECK; the comma word itself is output aligned.
REQ-020 SHALL in CHECK, on a comma at the current offset, increment the good count and go to LOCKED when it reaches LOCK_COUNT.
REQ-021 SHALL in CHECK, on a comma at another offset k, set offset to k, reset the good count to 1 and remain in CHECK.
REQ-022 SHALL in LOCKED hold offset frozen; a comma at the current offset clears the miss count, and a comma only at other offsets increments it.
REQ-023 SHALL in LOCKED go to HUNT and increment realign_cnt when the miss count reaches LOSS_COUNT.
REQ-024 SHALL clear the gap counter on each comma at the current offset and otherwise increment it, saturating.
REQ-025 SHALL in CHECK or LOCKED go to HUNT when the gap counter reaches 2^GAP_AW-1, incrementing realign_cnt only if leaving LOCKED.
REQ-026 SHALL force HUNT and clear all counts except realign_cnt whenever rx_los = 1, incrementing realign_cnt if leaving LOCKED, with rx_los taking priority over every other transition.
REQ-027 SHALL leave offset unchanged on entry to HUNT; rxd continues at the old offset until a new comma is found.
REQ-028 SHALL perform the good-count and miss-count updates and their terminal transitions on the same edge the qualifying comma is seen.

Reset
REQ-029 SHALL on rst = 1 clear P, rxd, comma, offset, realign_cnt and all counts, set state HUNT and drive locked = 0, all asynchronously.
REQ-030 SHALL on rst asserted mid-lock return to HUNT without incrementing realign_cnt.
REQ-031 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-032 SHALL cover: a K28.5/D16.2 stream shifted by 3 bits -> offset = 3 after the first comma; locked = 1 at the edge of the 3rd comma; rxd = K28.5 with comma = 1 thereafter.
REQ-033 SHALL cover: locked, then commas move to offset 7 -> locked drops after the 4th misplaced comma; realign_cnt increments 0 -> 1; relock at offset 7 after 3 more commas.
REQ-034 SHALL cover: locked, then 3 misplaced commas followed by 1 correct comma -> locked stays 1 and the miss count resets; 4 further misplaced commas are needed to drop lock.
REQ-035 SHALL cover: locked, then 255 consecutive words without a comma at the locked offset -> HUNT, locked = 0, realign_cnt +1; 254 words -> lock kept.
REQ-036 SHALL cover: rx_los pulsed for 1 cycle while locked -> locked = 0 on the next edge and realign_cnt +1; rst pulsed while locked -> all outputs 0 immediately and realign_cnt = 0.
REQ-037 SHALL cover: a window with commas at offsets 2 and 8 in one cycle while in HUNT -> offset = 2.
